// File: rtl/mult_wb.sv
// mult_wb - writeback buffer behind the pipelined multiplier.
//
// Captures each finished product with its destination tag. Holds up to DEPTH
// results in arrival order. Drains one result per cycle into the 64-bit
// register-file write port whenever that port is granted. Also answers a
// combinational "result pending" query for the issue logic.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-high reset
//   in_valid   multiplier presents a finished product
//   in_prod    product, 2*WIDTH bits
//   in_rd      destination register tag; tag 0 is discarded
//   in_ready   buffer can accept (occupancy below DEPTH)
//   wb_grant   register-file write port is free this cycle
//   rf_wctl    register-file write enable
//   rf_w       register-file write address (0 when empty)
//   rf_wd      register-file write data, zero-extended (0 when empty)
//   q_rd       hazard query register
//   q_pending  some buffered entry targets q_rd (never for q_rd == 0)
//   count      occupancy
//   ovf        sticky overflow, cleared only by rst
module mult_wb #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [2*WIDTH-1:0]       in_prod,
   input  logic [4:0]               in_rd,
   output logic                     in_ready,
   input  logic                     wb_grant,
   output logic                     rf_wctl,
   output logic [4:0]               rf_w,
   output logic [63:0]              rf_wd,
   input  logic [4:0]               q_rd,
   output logic                     q_pending,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = 2 * WIDTH;

   logic [4:0]    rd_mem_q   [DEPTH];
   logic [PW-1:0] prod_mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic          push;
   logic          pop;
   logic          has_head;
   logic [AW-1:0] age;

   assign has_head = (count_q != '0);

   // in_ready comes from registered occupancy only: a pop in the same cycle
   // does not open a slot for a push.
   assign in_ready = (count_q < CW'(DEPTH));
   assign rf_wctl  = has_head & wb_grant;
   assign rf_w     = has_head ? rd_mem_q[rd_ptr_q] : 5'd0;
   assign rf_wd    = has_head ? 64'(prod_mem_q[rd_ptr_q]) : 64'd0;
   assign count    = count_q;
   assign ovf      = ovf_q;

   assign push = in_valid & in_ready & (in_rd != 5'd0);
   assign pop  = rf_wctl;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // Refused product with a real destination is lost: flag it.
      if (in_valid & ~in_ready & (in_rd != 5'd0)) begin
         ovf_d = 1'b1;
      end
   end

   // Slot i is live when its distance from the read pointer is below the
   // occupancy; pointers alone cannot tell full from empty.
   always_comb begin
      q_pending = 1'b0;
      age       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         age = AW'(i) - rd_ptr_q;
         if (({1'b0, age} < count_q) && (rd_mem_q[i] == q_rd) && (q_rd != 5'd0)) begin
            q_pending = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset: occupancy decides which slots are meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem_q[wr_ptr_q]   <= in_rd;
         prod_mem_q[wr_ptr_q] <= in_prod;
      end
   end

endmodule

// File: tb/tb_mult_wb.sv
module tb_mult_wb;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   in_valid = 1'b0;
   logic [2*WIDTH-1:0]     in_prod = '0;
   logic [4:0]             in_rd = '0;
   logic                   in_ready;
   logic                   wb_grant = 1'b0;
   logic                   rf_wctl;
   logic [4:0]             rf_w;
   logic [63:0]            rf_wd;
   logic [4:0]             q_rd = '0;
   logic                   q_pending;
   logic [$clog2(DEPTH):0] count;
   logic                   ovf;

   mult_wb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_prod(in_prod), .in_rd(in_rd), .in_ready(in_ready),
      .wb_grant(wb_grant), .rf_wctl(rf_wctl), .rf_w(rf_w), .rf_wd(rf_wd),
      .q_rd(q_rd), .q_pending(q_pending), .count(count), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] prod;
   } ent_t;

   // Reference model: the buffer is a plain queue of expected writes.
   ent_t sb[$];
   ent_t pend;
   bit   pend_v   = 1'b0;
   bit   pend_ovf = 1'b0;
   bit   m_ovf    = 1'b0;
   int   tests    = 0;
   int   fails    = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit model_pending(logic [4:0] q);
      if (q == 5'd0) return 1'b0;
      foreach (sb[i]) if (sb[i].rd == q) return 1'b1;
      return 1'b0;
   endfunction

   // One cycle of stimulus. Whatever was accepted last cycle has now landed,
   // so it joins the model before this cycle's acceptance is decided.
   task automatic drive(bit v, logic [4:0] rd, logic [63:0] p, bit g, logic [4:0] q);
      @(posedge clk);
      #1;
      if (pend_v) sb.push_back(pend);
      if (pend_ovf) m_ovf = 1'b1;
      pend_v   = 1'b0;
      pend_ovf = 1'b0;
      in_valid = v;
      in_rd    = rd;
      in_prod  = p;
      wb_grant = g;
      q_rd     = q;
      if (v && rd != 5'd0) begin
         if (sb.size() < DEPTH) begin
            pend.rd   = rd;
            pend.prod = p;
            pend_v    = 1'b1;
         end else begin
            pend_ovf  = 1'b1;
         end
      end
   endtask

   task automatic reset_mid(logic [4:0] q);
      @(posedge clk);
      #3;
      rst      = 1'b1;
      sb.delete();
      pend_v   = 1'b0;
      pend_ovf = 1'b0;
      m_ovf    = 1'b0;
      in_valid = 1'b0;
      wb_grant = 1'b1;
      q_rd     = q;
      #1;
      chk("rst_count", count, 0);
      chk("rst_wctl", rf_wctl, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_q_pending", q_pending, 0);
      chk("rst_rf_w", rf_w, 0);
      chk("rst_rf_wd", rf_wd, 0);
      chk("rst_ovf", ovf, 0);
      @(negedge clk);
      #2;
      rst = 1'b0;
   endtask

   // Monitor: compares the DUT against the model every cycle, away from the
   // active edge, and retires the head entry when a write is expected.
   initial begin
      bit exp_w;
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_w = wb_grant && (sb.size() > 0);
            chk("count", count, sb.size());
            chk("in_ready", in_ready, sb.size() < DEPTH);
            chk("ovf", ovf, m_ovf);
            chk("q_pending", q_pending, model_pending(q_rd));
            chk("rf_wctl", rf_wctl, exp_w);
            if (sb.size() == 0) begin
               chk("rf_w_empty", rf_w, 0);
               chk("rf_wd_empty", rf_wd, 0);
            end else begin
               chk("rf_w", rf_w, sb[0].rd);
               chk("rf_wd", rf_wd, sb[0].prod);
            end
            if (rf_wctl) chk("rf_w_nonzero", rf_w != 5'd0, 1);
            if (exp_w) void'(sb.pop_front());
         end
      end
   end

   initial begin
      #12;
      rst = 1'b0;

      // single push, minimum latency
      drive(1, 5'd5, 64'h0000_0006_0000_0007, 1, 5'd5);
      drive(0, 5'd0, 64'd0, 1, 5'd0);
      #1;
      chk("lat_wctl", rf_wctl, 1);
      chk("lat_rf_w", rf_w, 5);
      chk("lat_rf_wd", rf_wd, 64'h0000_0006_0000_0007);
      drive(0, 5'd0, 64'd0, 1, 5'd0);
      #1;
      chk("lat_drained", count, 0);

      // grant blocked, then full drain
      for (int i = 1; i <= 4; i++) drive(1, 5'(i), 64'(100 + i), 0, 5'd3);
      drive(0, 5'd0, 64'd0, 0, 5'd3);
      #1;
      chk("blk_full", in_ready, 0);
      chk("blk_q3", q_pending, 1);
      drive(0, 5'd0, 64'd0, 0, 5'd7);
      #1;
      chk("blk_q7", q_pending, 0);

      // overflow while full with a pop in the same cycle
      drive(1, 5'd9, 64'h999, 1, 5'd9);
      for (int i = 0; i < 6; i++) drive(0, 5'd0, 64'd0, 1, 5'd9);
      #1;
      chk("ovf_sticky", ovf, 1);

      // rd 0 discard and duplicate tags
      drive(1, 5'd0, 64'hFF, 0, 5'd6);
      drive(1, 5'd6, 64'd10, 0, 5'd6);
      drive(1, 5'd6, 64'd20, 0, 5'd0);
      drive(0, 5'd0, 64'd0, 0, 5'd6);
      #1;
      chk("dup_count", count, 2);
      for (int i = 0; i < 3; i++) drive(0, 5'd0, 64'd0, 1, 5'd6);

      // sustained push/pop across pointer wrap
      for (int i = 0; i < 3 * DEPTH; i++)
         drive(1, 5'((i % 31) + 1), 64'h1000 + 64'(i), 1, 5'((i % 31) + 1));
      for (int i = 0; i < 3; i++) drive(0, 5'd0, 64'd0, 1, 5'd0);

      // reset with entries buffered
      for (int i = 0; i < 3; i++) drive(1, 5'(10 + i), 64'(200 + i), 0, 5'd11);
      reset_mid(5'd11);
      for (int i = 0; i < 4; i++) drive(0, 5'd0, 64'd0, 1, 5'd11);

      // randomized traffic
      for (int i = 0; i < 400; i++)
         drive(($urandom % 4) != 0, 5'($urandom % 8), {$urandom, $urandom},
               ($urandom % 3) != 0, 5'($urandom % 8));
      reset_mid(5'd3);
      for (int i = 0; i < 200; i++)
         drive(($urandom % 3) != 0, 5'($urandom % 32), {$urandom, $urandom},
               ($urandom % 2) != 0, 5'($urandom % 32));
      for (int i = 0; i < 8; i++) drive(0, 5'd0, 64'd0, 1, 5'd0);
      @(negedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
